// File: rtl/comparator_search.sv
// Binary-search initiator for a combinational magnitude comparator; recovers the value on its a input.
// Latency: 1..WIDTH+1 compares, one cycle each (two with CMP_SETTLE_EN); start is ignored while busy.
// Optional feature macro CMP_SETTLE_EN inserts a SETTLE cycle after every guess update.
module comparator_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             g,
    input  logic             e,
    input  logic             l,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [2:0]       steps
);

`ifdef CMP_SETTLE_EN
    typedef enum logic [1:0] {IDLE, SEARCH, SETTLE} state_t;
    localparam state_t AFTER_UPDATE = SETTLE;
`else
    typedef enum logic [1:0] {IDLE, SEARCH} state_t;
    localparam state_t AFTER_UPDATE = SEARCH;
`endif

    localparam logic [WIDTH-1:0] RANGE_MAX = '1;
    localparam logic [WIDTH-1:0] FIRST_MID = RANGE_MAX >> 1;

    state_t           state, state_n;
    logic [WIDTH-1:0] lo, hi, lo_n, hi_n;
    logic [WIDTH-1:0] guess_n, result_n;
    logic             busy_n, done_n, err_n;
    logic [2:0]       steps_n;

    // Midpoint sums carry one extra bit so lo+hi never wraps.
    logic [WIDTH:0]   sum_up, sum_dn;
    assign sum_up = {1'b0, guess} + {1'b0, hi} + (WIDTH+1)'(1);
    assign sum_dn = {1'b0, lo} + {1'b0, guess} - (WIDTH+1)'(1);

    always_comb begin
        state_n  = state;
        lo_n     = lo;
        hi_n     = hi;
        guess_n  = guess;
        result_n = result;
        busy_n   = busy;
        done_n   = 1'b0;
        err_n    = err;
        steps_n  = steps;
        case (state)
            IDLE: begin
                if (start) begin
                    lo_n    = '0;
                    hi_n    = RANGE_MAX;
                    guess_n = FIRST_MID;
                    steps_n = '0;
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = AFTER_UPDATE;
                end
            end
            SEARCH: begin
                steps_n = steps + 3'd1;
                if (e && !g && !l) begin
                    result_n = guess;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end else if (g && !e && !l && guess != hi) begin
                    lo_n    = guess + WIDTH'(1);
                    guess_n = sum_up[WIDTH:1];
                    state_n = AFTER_UPDATE;
                end else if (l && !g && !e && guess != lo) begin
                    hi_n    = guess - WIDTH'(1);
                    guess_n = sum_dn[WIDTH:1];
                    state_n = AFTER_UPDATE;
                end else begin
                    // Flag combination impossible for a sane comparator, or range exhausted.
                    err_n    = 1'b1;
                    result_n = guess;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end
            end
`ifdef CMP_SETTLE_EN
            SETTLE: begin
                state_n = SEARCH;
            end
`endif
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            lo     <= '0;
            hi     <= '0;
            guess  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            steps  <= '0;
        end else begin
            state  <= state_n;
            lo     <= lo_n;
            hi     <= hi_n;
            guess  <= guess_n;
            result <= result_n;
            busy   <= busy_n;
            done   <= done_n;
            err    <= err_n;
            steps  <= steps_n;
        end
    end

endmodule
